col_kernel_ix_ctrl: RTL

//  Raster sequencer for the column central-difference Ix kernel. Accepts one pixel/cycle of a raster frame.

---
 rtl/lk_pkg.sv | 14 +
 rtl/line_buf_2row.sv | 21 ++
 rtl/col_kernel_ix_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/lk_pkg.sv
// rtl/lk_pkg.sv - shared constants and types for the column Ix kernel controller
package lk_pkg;
  localparam int PIX_W     = 12;
  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;
  localparam int X_W_DEF   = $clog2(IMG_W_DEF);
  localparam int Y_W_DEF   = $clog2(IMG_H_DEF);

  typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DONE} ixc_state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/line_buf_2row.sv
// rtl/line_buf_2row.sv - two-line pixel store, async read, sync write
module line_buf_2row #(
  parameter int DEPTH = 1280,
  parameter int PIX_W = 12,
  parameter int A_W   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [A_W-1:0]   addr_i,
  input  logic [PIX_W-1:0] wdata_i,
  output logic [PIX_W-1:0] rdata_o
);
  logic [PIX_W-1:0] mem_q [DEPTH];

  // Async read returns the old word even when the same slot is written this cycle.
  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end
endmodule

// File: rtl/col_kernel_ix_ctrl.sv
// rtl/col_kernel_ix_ctrl.sv - raster sequencer feeding vertical pixel pairs to col_kernel_ix
module col_kernel_ix_ctrl
  import lk_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int PIX_W = lk_pkg::PIX_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [PIX_W-1:0]         in_pixel,
  output logic                     in_ready,
  output logic [PIX_W-1:0]         row0_pixel,
  output logic [PIX_W-1:0]         row2_pixel,
  output logic                     ix_valid,
  output logic                     ix_border,
  output logic [$clog2(IMG_W)-1:0] ix_x,
  output logic [$clog2(IMG_H)-1:0] ix_y,
  output logic                     busy,
  output logic                     frame_done
);
  localparam int X_W = cnt_w(IMG_W);
  localparam int Y_W = cnt_w(IMG_H);
  localparam int A_W = $clog2(2 * IMG_W);
  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);
  localparam logic [Y_W-1:0] Y_ONE  = Y_W'(1);

  ixc_state_t       state_q, state_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic             accept;
  logic [A_W-1:0]   buf_addr;
  logic [PIX_W-1:0] buf_rdata;

  logic [PIX_W-1:0] row0_q, row0_d, row2_q, row2_d;
  logic             em_valid_q, em_valid_d, em_border_q, em_border_d, em_last_q, em_last_d;
  logic [X_W-1:0]   em_x_q, em_x_d;
  logic [Y_W-1:0]   em_y_q, em_y_d;
  logic             ix_valid_q, ix_border_q, frame_done_q;
  logic [X_W-1:0]   ix_x_q;
  logic [Y_W-1:0]   ix_y_q;

  assign in_ready = (state_q == FILL) || (state_q == RUN);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != IDLE);

  // Row parity selects the slot, so row y overwrites row y-2 as it is read.
  assign buf_addr = y_q[0] ? (A_W'(IMG_W) + A_W'(x_q)) : A_W'(x_q);

  line_buf_2row #(.DEPTH(2 * IMG_W), .PIX_W(PIX_W), .A_W(A_W)) u_line_buf (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (buf_addr),
    .wdata_i (in_pixel),
    .rdata_o (buf_rdata)
  );

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    row0_d      = row0_q;
    row2_d      = row2_q;
    em_valid_d  = 1'b0;
    em_x_d      = em_x_q;
    em_y_d      = em_y_q;
    em_border_d = em_border_q;
    em_last_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILL;
          x_d     = '0;
          y_d     = '0;
        end
      end
      FILL: begin
        if (accept) begin
          if (x_q == X_LAST) begin
            x_d     = '0;
            y_d     = Y_ONE;
            state_d = RUN;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      RUN: begin
        if (accept) begin
          em_valid_d  = 1'b1;
          em_x_d      = x_q;
          em_y_d      = y_q - Y_ONE;
          em_border_d = (y_q == Y_ONE);
          row0_d      = (y_q == Y_ONE) ? '0 : buf_rdata;
          row2_d      = (y_q == Y_ONE) ? '0 : in_pixel;
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) state_d = FLUSH;
            else               y_d     = y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        // Bottom border row has no lower neighbour; emit it with zeroed pixels.
        em_valid_d  = 1'b1;
        em_x_d      = x_q;
        em_y_d      = Y_LAST;
        em_border_d = 1'b1;
        row0_d      = '0;
        row2_d      = '0;
        em_last_d   = (x_q == X_LAST);
        if (x_q == X_LAST) begin
          x_d     = '0;
          state_d = DONE;
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      DONE: begin
        y_d     = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      row0_q       <= '0;
      row2_q       <= '0;
      em_valid_q   <= 1'b0;
      em_x_q       <= '0;
      em_y_q       <= '0;
      em_border_q  <= 1'b0;
      em_last_q    <= 1'b0;
      ix_valid_q   <= 1'b0;
      ix_x_q       <= '0;
      ix_y_q       <= '0;
      ix_border_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      row0_q       <= row0_d;
      row2_q       <= row2_d;
      em_valid_q   <= em_valid_d;
      em_x_q       <= em_x_d;
      em_y_q       <= em_y_d;
      em_border_q  <= em_border_d;
      em_last_q    <= em_last_d;
      // One-cycle delay lines the tags up with the kernel's registered output.
      ix_valid_q   <= em_valid_q;
      ix_x_q       <= em_x_q;
      ix_y_q       <= em_y_q;
      ix_border_q  <= em_border_q;
      frame_done_q <= em_valid_q && em_last_q;
    end
  end

  assign row0_pixel = row0_q;
  assign row2_pixel = row2_q;
  assign ix_valid   = ix_valid_q;
  assign ix_x       = ix_x_q;
  assign ix_y       = ix_y_q;
  assign ix_border  = ix_border_q;
  assign frame_done = frame_done_q;
endmodule
